// File: rtl/alu_writeback_rf_pkg.sv
// Shared constants and types for the writeback stage and its register file.
package alu_writeback_rf_pkg;

  localparam int DW    = 8;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_idx_t;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic          flag_we;
    logic          carry;
    reg_idx_t      dest;
    logic [DW-1:0] result;
  } wb_entry_t;

endpackage

// File: rtl/alu_writeback_rf_rf_core.sv
// Register file storage: one synchronous write port, two combinational read ports.
module rf_core #(
  parameter int DW    = 8,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_q [NREGS];

  // NOTE: the storage is reset entry by entry because the architecture defines
  // every register as 0 after reset; this rules out mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      // NOTE: state is written with <= so every flop samples pre-edge values.
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_writeback_rf.sv
// WB pipeline register, zero/carry flags and forwarding around the register file.
module alu_writeback_rf
  import alu_writeback_rf_pkg::*;
#(
  parameter bit HARDWIRE_R0 = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid_i,
  input  logic [DW-1:0] ex_result_i,
  input  reg_idx_t      ex_dest_i,
  input  logic          ex_we_i,
  input  logic          ex_carry_i,
  input  logic          ex_flag_we_i,
  input  logic          flush_i,
  input  reg_idx_t      raddr_a_i,
  input  reg_idx_t      raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o,
  output logic          zero_o,
  output logic          carry_o,
  output logic          wb_valid_o
);

  wb_entry_t     wb_q, wb_d;
  logic          zero_q, carry_q;
  logic          commit, rf_we, fwd_a, fwd_b;
  logic [DW-1:0] rf_a, rf_b;

  // NOTE: every field gets a value on every path, so no latch can be inferred.
  always_comb begin
    wb_d         = '0;
    wb_d.valid   = ex_valid_i;
    wb_d.we      = ex_we_i & ex_valid_i;
    wb_d.flag_we = ex_flag_we_i & ex_valid_i;
    wb_d.carry   = ex_carry_i;
    wb_d.dest    = ex_dest_i;
    wb_d.result  = ex_result_i;
  end

  assign commit = wb_q.valid & ~flush_i;
  assign rf_we  = commit & wb_q.we & ~(HARDWIRE_R0 && wb_q.dest == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      wb_q <= wb_d;
      if (commit && wb_q.flag_we) begin
        zero_q  <= ~|wb_q.result;
        carry_q <= wb_q.carry;
      end
    end
  end

  rf_core #(.DW(DW), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .we_i      (rf_we),
    .waddr_i   (wb_q.dest),
    .wdata_i   (wb_q.result),
    .raddr_a_i (raddr_a_i),
    .raddr_b_i (raddr_b_i),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  // The pending WB value is younger than anything in the RF, so it wins.
  assign fwd_a = commit & wb_q.we & (raddr_a_i == wb_q.dest);
  assign fwd_b = commit & wb_q.we & (raddr_b_i == wb_q.dest);

  assign rdata_a_o = (HARDWIRE_R0 && raddr_a_i == '0) ? '0 : (fwd_a ? wb_q.result : rf_a);
  assign rdata_b_o = (HARDWIRE_R0 && raddr_b_i == '0) ? '0 : (fwd_b ? wb_q.result : rf_b);

  assign zero_o     = zero_q;
  assign carry_o    = carry_q;
  assign wb_valid_o = wb_q.valid;

endmodule

// File: doc/alu_writeback_rf.md
Name: alu_writeback_rf

Overview:
- Writeback stage plus register file that consumes the 8-bit ALU result selected by the ALU output mux.
- Registers the EX-stage result in a one-entry WB pipeline register and commits it to an 8x8 register file at the end of the WB cycle.
- Maintains the zero and carry status flags.
- Two combinational read ports, with forwarding from the pending WB entry, feed the ALU operand path.

Parameters:
- DW, 8, data width (matches the ALU data path)
- NREGS, 8, number of architectural registers; AW = $clog2(NREGS) = 3
- HARDWIRE_R0, 0, when 1, register 0 always reads 0 and writes to it are discarded

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- ex_valid_i  input  1  EX stage presents a valid instruction this cycle
- ex_result_i  input  DW  ALU result (the mux output)
- ex_dest_i  input  AW  destination register index
- ex_we_i  input  1  instruction writes the register file
- ex_carry_i  input  1  carry produced by the ALU
- ex_flag_we_i  input  1  instruction updates the zero/carry flags
- flush_i  input  1  kill the entry currently held in the WB register
- raddr_a_i  input  AW  read address, port A
- raddr_b_i  input  AW  read address, port B
- rdata_a_o  output  DW  read data, port A (combinational)
- rdata_b_o  output  DW  read data, port B (combinational)
- zero_o  output  1  committed zero flag
- carry_o  output  1  committed carry flag
- wb_valid_o  output  1  WB register holds a live entry this cycle

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- When reset=1 at a rising edge:
  - every register file entry becomes 0;
  - wb_valid, zero_o and carry_o become 0;
  - WB data, destination and control fields become 0.
- Reset overrides every other input. A WB entry pending when reset arrives is discarded and never commits.
- WB capture, each edge when not in reset:
  - wb_valid <= ex_valid_i;
  - wb_result, wb_dest, wb_we, wb_carry and wb_flag_we load from the ex_* inputs;
  - each control field is ANDed with ex_valid_i, so a bubble carries no write enables.
- Commit: an entry captured at edge N commits at edge N+1, provided wb_valid=1 and flush_i=0 during the cycle between.
  - If wb_we=1, RF[wb_dest] <= wb_result.
  - If wb_flag_we=1, zero_o <= (wb_result == 0) and carry_o <= wb_carry.
  - Latency from EX-valid to architectural visibility is 2 edges. The value is forwarded after 1 edge.
- flush_i=1 suppresses both the RF write and the flag update for the entry currently in WB. It has no effect on the EX inputs captured on the same edge.
- Reads: rdata_x = RF[raddr_x], with two overrides:
  - Forwarding: if wb_valid && wb_we && !flush_i && raddr_x == wb_dest, then rdata_x = wb_result.
  - HARDWIRE_R0=1: reading address 0 returns 0 regardless of forwarding, and the commit to address 0 is gated off.
- Both ports may read the same address. Each resolves independently and gives an identical result.
- Back-to-back writes to the same register: each commits in order. Reads always see the younger (WB) value over the RF value.
- Flags update only on flag-writing instructions. Otherwise they hold, including across bubbles and flushed entries.
- Width rule: all data is exactly DW bits, with no extension or truncation. The zero flag is a reduction-NOR over DW bits.
- No combinational path from the ex_* inputs to any output.

Decomposition:
- Shared package holds:
  - DW, AW and NREGS constants;
  - a typedef for the register index;
  - a packed wb_entry_t struct {valid, we, flag_we, carry, dest, result}.
- One natural sub-module, rf_core: the NREGS x DW storage with a synchronous write port and two combinational read ports.
- Forwarding, flags and the WB register live in the top module.

Test Plan:
- Reset, then read all 8 addresses on both ports -> all return 0x00; zero_o=0, carry_o=0, wb_valid_o=0.
- EX writes 0x5A to r3 (we=1) -> after edge 1, reading r3 returns 0x5A via forwarding; after edge 2, RF[3]=0x5A with ex_valid_i=0.
- EX result 0x00, carry=1, flag_we=1, we=0 -> after commit, zero_o=1 and carry_o=1, and no register changes. A following flag_we=0 entry leaves the flags unchanged.
- Write 0x11 then 0x22 to r5 on consecutive cycles, reading r5 every cycle -> reads 0x11, then 0x22, then a final committed 0x22.
- Capture a write of 0xFF to r2, then assert flush_i in the WB cycle -> forwarding is off that cycle, RF[2] stays at its old value, and the flags are unchanged.
- Capture a write of 0x77 to r1, then assert reset in the WB cycle -> RF[1]=0x00 and wb_valid_o=0 next cycle. With HARDWIRE_R0=1, a write of 0x33 to r0 reads back 0x00 on both ports at all times.
